// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit add/subtract split into STAGES carry-chain
// segments with valid/ready handshakes and a global stall.
module pipelined_add_sub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  logic adv;

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;

  logic [STAGES-1:0]            v_s;
  logic [STAGES-1:0]            c_s;
  logic [STAGES-1:0][WIDTH-1:0] a_s;
  logic [STAGES-1:0][WIDTH-1:0] b_s;
  logic [STAGES-1:0][WIDTH-1:0] s_s;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // stage 0 takes the operands straight from the ports
  assign v_s[0] = in_valid;
  assign a_s[0] = a;
  assign b_s[0] = sub ? ~b : b;
  assign c_s[0] = sub | carry_in;
  assign s_s[0] = '0;

  genvar k;
  generate
    for (k = 1; k < STAGES; k++) begin : g_src
      assign v_s[k] = v_q[k-1];
      assign a_s[k] = a_q[k-1];
      assign b_s[k] = b_q[k-1];
      assign c_s[k] = c_q[k-1];
      assign s_s[k] = s_q[k-1];
    end

    for (k = 0; k < STAGES; k++) begin : g_st
      logic [CHUNK:0]   r;
      logic [WIDTH-1:0] s_n;

      // resolve this stage's chunk and merge it into the partial sum
      always_comb begin
        r = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
          + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, c_s[k]};
        s_n = s_s[k];
        s_n[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      end

      // stage register: shifts on adv, data loaded only for valid beats
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q[k] <= 1'b0;
          c_q[k] <= 1'b0;
          a_q[k] <= '0;
          b_q[k] <= '0;
          s_q[k] <= '0;
        end else if (adv) begin
          v_q[k] <= v_s[k];
          if (v_s[k]) begin
            c_q[k] <= r[CHUNK];
            a_q[k] <= a_s[k];
            b_q[k] <= b_s[k];
            s_q[k] <= s_n;
          end
        end
      end
    end
  endgenerate

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB])
                   & (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed checks of the pipelined adder
// for the 8/2, 16/4 and 8/1 configurations.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv = 1'b0, ordy = 1'b0, ci = 1'b0, sb = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ir, ov, co, of;
  logic [7:0] s;

  logic        viv = 1'b0, vci = 1'b0, vsb = 1'b0, vordy = 1'b1;
  logic [15:0] va = '0, vb = '0;
  logic        ir4, ov4, co4, of4, ir1, ov1, co1, of1;
  logic [15:0] s4;
  logic [7:0]  s1;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
    .a(a), .b(b), .carry_in(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy), .sum(s),
    .carry_out(co), .overflow(of)
  );

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(viv), .in_ready(ir4),
    .a(va), .b(vb), .carry_in(vci), .sub(vsb),
    .out_valid(ov4), .out_ready(vordy), .sum(s4),
    .carry_out(co4), .overflow(of4)
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(viv), .in_ready(ir1),
    .a(va[7:0]), .b(vb[7:0]), .carry_in(vci), .sub(vsb),
    .out_valid(ov1), .out_ready(vordy), .sum(s1),
    .carry_out(co1), .overflow(of1)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] beats[$];
  logic [9:0]  expq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {overflow, carry_out, sum} of an 8-bit beat
  function automatic logic [9:0] model(input logic [7:0] x, y,
                                       input logic c, m);
    logic [7:0] yp;
    logic [8:0] t;
    yp = m ? ~y : y;
    t  = {1'b0, x} + {1'b0, yp} + {8'd0, (m | c)};
    return {((x[7] == yp[7]) && (t[7] != x[7])), t};
  endfunction

  task automatic drive(input int n);
    logic acc;
    int   w;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      {ci, sb, a, b} = beats.pop_front();
      iv = 1'b1;
      w  = 0;
      forever begin
        @(negedge clk) acc = ir;
        @(posedge clk);
        if (acc) break;
        w++;
        if (w > 50) begin
          chk("drv_timeout", 1, 0);
          break;
        end
      end
      expq.push_back(model(a, b, ci, sb));
      #1;
    end
    iv = 1'b0;
  endtask

  task automatic monitor(input int budget, output int got,
                         output int first, output int last);
    logic [9:0] e;
    got = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (ov && ordy) begin
        if (expq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = expq.pop_front();
          chk("beat", {22'd0, of, co, s}, {22'd0, e});
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
  endtask

  task automatic single(input string tag, input logic [7:0] x, y,
                        input logic c, m, input logic [9:0] exp);
    int lat;
    ordy = 1'b1;
    @(posedge clk); #1;
    a = x; b = y; ci = c; sb = m; iv = 1'b1;
    @(negedge clk) chk({tag, "_ready"}, ir, 1);
    @(posedge clk); #1;
    iv  = 1'b0;
    lat = 1;
    while (!ov && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk(tag, {22'd0, of, co, s}, {22'd0, exp});
  endtask

  initial begin
    int got, first, last, cnt, lat4, lat1;
    logic [17:0] r4;
    logic [9:0]  r1, hold_exp;

    #2;
    chk("rst_ov", ov, 0);
    chk("rst_sum", s, 0);
    chk("rst_ready", ir, 1);
    chk("rst_ov4", ov4, 0);
    @(negedge clk) rst = 1'b0;

    // reset with two beats in flight
    ordy = 1'b1;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; ci = 0; sb = 0; iv = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    iv = 1'b0;
    chk("pre_rst_ov", ov, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ov", ov, 0);
    chk("rst_mid_sum", s, 0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    repeat (8) @(negedge clk) if (ov) cnt++;
    chk("ghost_beats", cnt, 0);

    single("add_f0_1f", 8'hF0, 8'h1F, 1'b1, 1'b0, 10'h110);
    single("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
    single("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 10'h37F);
    repeat (3) @(posedge clk);

    // back-to-back stream
    ordy = 1'b1;
    for (int i = 0; i < 16; i++) beats.push_back(18'($urandom));
    fork
      drive(16);
      monitor(30, got, first, last);
    join
    chk("b2b_count", got, 16);
    chk("b2b_contig", last - first, 15);
    chk("b2b_left", expq.size(), 0);

    // backpressure with a full pipe
    ordy = 1'b0;
    beats.push_back({1'b0, 1'b0, 8'h7F, 8'h01});
    beats.push_back({1'b1, 1'b1, 8'h10, 8'h20});
    beats.push_back({1'b1, 1'b0, 8'hFF, 8'hFF});
    beats.push_back({1'b0, 1'b1, 8'h00, 8'h00});
    hold_exp = 10'h280;
    fork
      drive(4);
      monitor(40, got, first, last);
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!ov && cnt < 20);
        for (int k = 0; k < 5; k++) begin
          chk("stall_ready", ir, 0);
          chk("stall_hold", {22'd0, of, co, s}, {22'd0, hold_exp});
          @(negedge clk);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
      end
    join
    chk("bp_count", got, 4);
    chk("bp_left", expq.size(), 0);

    // other parameterisations: 16/4 and 8/1
    @(posedge clk); #1;
    va = 16'hFFF0; vb = 16'h001F; vci = 1'b1; viv = 1'b1;
    @(posedge clk); #1;
    viv = 1'b0;
    lat4 = 0; lat1 = 0; r4 = '0; r1 = '0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (ov4 && lat4 == 0) begin
        lat4 = cyc;
        r4   = {of4, co4, s4};
      end
      if (ov1 && lat1 == 0) begin
        lat1 = cyc;
        r1   = {of1, co1, s1};
      end
      @(posedge clk); #1;
    end
    chk("w16_lat", lat4, 4);
    chk("w16_add", {14'd0, r4}, 32'h10010);
    chk("s1_lat", lat1, 1);
    chk("s1_add", {22'd0, r1}, 32'h110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
